// File: rtl/norm_shift.sv
// Two-stage normalize/denormalize shifter for the rounder datapath.
// Stage 1 registers the operand and sticky; stage 2 registers the shifted result.
module norm_shift #(
  parameter int WF = 64,
  parameter int WE = 13
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [WF-1:0] fi,
  input  logic [WE-1:0] ei,
  input  logic [WE-1:0] sh,
  input  logic [WF-1:0] v,
  input  logic [WF-1:0] w,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [WF-1:0] fo,
  output logic [WE-1:0] eo,
  output logic          sticky,
  output logic          zero
);

  localparam int SW = $clog2(WF);

  logic          s1Valid_q;
  logic [WF-1:0] s1Fi_q;
  logic [WE-1:0] s1Ei_q;
  logic [WE-1:0] s1Sh_q;
  logic [WF-1:0] s1V_q;
  logic          s1Sticky_q;

  logic          s2Valid_q;
  logic [WF-1:0] s2Fo_q;
  logic [WE-1:0] s2Eo_q;
  logic          s2Sticky_q;
  logic          s2Zero_q;

  logic          s1Adv;
  logic          s2Adv;

  logic          shNeg;
  logic [WE:0]   shMag;
  logic          shSat;
  logic [SW-1:0] shAmt;
  logic [WF-1:0] shiftIn;
  logic [WF-1:0] shiftStage;
  logic [WF-1:0] shifted;

  logic [WF-1:0] s2Fo_d;
  logic [WE-1:0] s2Eo_d;
  logic          s2Zero_d;

  assign s2Adv    = !s2Valid_q || out_ready;
  assign s1Adv    = !s1Valid_q || s2Adv;
  assign in_ready = s1Adv;

  // Magnitude is one bit wider than sh so that -2^(WE-1) does not overflow.
  assign shNeg = s1Sh_q[WE-1];
  assign shMag = shNeg ? ((WE+1)'(0) - {s1Sh_q[WE-1], s1Sh_q}) : {1'b0, s1Sh_q};
  assign shSat = (shMag >= (WE+1)'(WF));
  assign shAmt = shMag[SW-1:0];

  // One left barrel shifter serves both directions by bit-reversing around it.
  always_comb begin
    shiftIn    = '0;
    shiftStage = '0;
    shifted    = '0;
    for (int i = 0; i < WF; i++) begin
      shiftIn[i] = shNeg ? s1Fi_q[WF-1-i] : s1Fi_q[i];
    end
    shiftStage = shiftIn;
    for (int k = 0; k < SW; k++) begin
      if (shAmt[k]) begin
        shiftStage = shiftStage << (1 << k);
      end
    end
    for (int i = 0; i < WF; i++) begin
      shifted[i] = shNeg ? shiftStage[WF-1-i] : shiftStage[i];
    end
    if (shSat) begin
      shifted = '0;
    end
  end

  always_comb begin
    s2Fo_d   = shifted & s1V_q;
    s2Eo_d   = s1Ei_q - s1Sh_q;
    s2Zero_d = (s2Fo_d == '0);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s1Valid_q  <= 1'b0;
      s1Fi_q     <= '0;
      s1Ei_q     <= '0;
      s1Sh_q     <= '0;
      s1V_q      <= '0;
      s1Sticky_q <= 1'b0;
      s2Valid_q  <= 1'b0;
      s2Fo_q     <= '0;
      s2Eo_q     <= '0;
      s2Sticky_q <= 1'b0;
      s2Zero_q   <= 1'b0;
    end else begin
      if (s1Adv) begin
        s1Valid_q <= in_valid;
        if (in_valid) begin
          s1Fi_q     <= fi;
          s1Ei_q     <= ei;
          s1Sh_q     <= sh;
          s1V_q      <= v;
          s1Sticky_q <= |(fi & w);
        end
      end
      // Output registers only load real results, so they keep reset values until the first one.
      if (s2Adv) begin
        s2Valid_q <= s1Valid_q;
        if (s1Valid_q) begin
          s2Fo_q     <= s2Fo_d;
          s2Eo_q     <= s2Eo_d;
          s2Sticky_q <= s1Sticky_q;
          s2Zero_q   <= s2Zero_d;
        end
      end
    end
  end

  assign out_valid = s2Valid_q;
  assign fo        = s2Fo_q;
  assign eo        = s2Eo_q;
  assign sticky    = s2Sticky_q;
  assign zero      = s2Zero_q;

endmodule

// File: tb/tb_norm_shift.sv
// Self-checking bench for norm_shift: directed vectors, random traffic against
// an arithmetic reference model, throughput, backpressure and mid-flight reset.
module tb_norm_shift;

  localparam int WF = 64;
  localparam int WE = 13;

  logic          clk = 1'b0;
  logic          rst;
  logic          in_valid;
  logic          in_ready;
  logic [WF-1:0] fi;
  logic [WE-1:0] ei;
  logic [WE-1:0] sh;
  logic [WF-1:0] v;
  logic [WF-1:0] w;
  logic          out_valid;
  logic          out_ready;
  logic [WF-1:0] fo;
  logic [WE-1:0] eo;
  logic          sticky;
  logic          zero;

  typedef struct packed {
    logic [63:0] fo;
    logic [12:0] eo;
    logic        sticky;
    logic        zero;
  } res_t;

  res_t expQ[$];
  res_t gotQ[$];
  int   compared   = 0;
  int   mismatched = 0;
  int   accepted   = 0;
  int   emitted    = 0;

  always #5 clk = ~clk;

  norm_shift #(.WF(WF), .WE(WE)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .fi(fi), .ei(ei), .sh(sh), .v(v), .w(w),
    .out_valid(out_valid), .out_ready(out_ready),
    .fo(fo), .eo(eo), .sticky(sticky), .zero(zero)
  );

  // Mask the upstream generator would supply: the bits a right shift discards.
  function automatic logic [63:0] wFor(input logic [12:0] s);
    int d;
    int m;
    d = int'($signed(s));
    m = (d < 0) ? -d : d;
    if (d >= 0) return 64'd0;
    if (m >= 64) return '1;
    return (64'd1 << m) - 64'd1;
  endfunction

  // Result from the arithmetic definition of the shift, not from any gate structure.
  function automatic res_t refModel(input logic [63:0] f, input logic [12:0] e,
                                    input logic [12:0] s, input logic [63:0] vm);
    res_t        r;
    int          d;
    int          m;
    logic [63:0] shifted;
    d = int'($signed(s));
    m = (d < 0) ? -d : d;
    r.sticky = 1'b0;
    if (m >= 64) begin
      shifted = 64'd0;
      if (d < 0) r.sticky = (f != 64'd0);
    end else if (d >= 0) begin
      shifted = f << m;
    end else begin
      shifted  = f >> m;
      r.sticky = ((f % (64'd1 << m)) != 64'd0);
    end
    r.fo   = shifted & vm;
    r.eo   = e - s;
    r.zero = (r.fo == 64'd0);
    return r;
  endfunction

  task automatic stepCycle(input logic iv, input logic ordy, input logic [63:0] f,
                           input logic [12:0] e, input logic [12:0] s, input logic [63:0] vm);
    res_t r;
    @(negedge clk);
    in_valid  = iv;
    out_ready = ordy;
    fi = f;
    ei = e;
    sh = s;
    v  = vm;
    w  = wFor(s);
    #1;
    if (!rst && out_valid && out_ready) begin
      r.fo = fo;
      r.eo = eo;
      r.sticky = sticky;
      r.zero = zero;
      gotQ.push_back(r);
      emitted++;
    end
    if (!rst && in_valid && in_ready) begin
      expQ.push_back(refModel(f, e, s, vm));
      accepted++;
    end
  endtask

  task automatic idleCycle(input logic ordy);
    stepCycle(1'b0, ordy, 64'd0, 13'd0, 13'd0, 64'd0);
  endtask

  task automatic drain();
    for (int i = 0; i < 20 && accepted != emitted; i++) idleCycle(1'b1);
  endtask

  function automatic logic [12:0] randShift();
    if ($urandom_range(0, 3) == 0) return 13'($urandom);
    return 13'($urandom_range(0, 140)) - 13'd70;
  endfunction

  function automatic logic [63:0] randSig();
    if ($urandom_range(0, 3) == 0) return 64'($urandom_range(0, 255));
    return {$urandom, $urandom};
  endfunction

  task automatic test_reset();
    rst = 1'b1;
    idleCycle(1'b1);
    idleCycle(1'b1);
    rst = 1'b0;
    idleCycle(1'b1);
    compared += 6;
    if (out_valid !== 1'b0) begin mismatched++; $display("[TB] FAIL reset out_valid: got %b expected 0", out_valid); end
    if (fo !== 64'd0) begin mismatched++; $display("[TB] FAIL reset fo: got %h expected 0", fo); end
    if (eo !== 13'd0) begin mismatched++; $display("[TB] FAIL reset eo: got %h expected 0", eo); end
    if (sticky !== 1'b0) begin mismatched++; $display("[TB] FAIL reset sticky: got %b expected 0", sticky); end
    if (zero !== 1'b0) begin mismatched++; $display("[TB] FAIL reset zero: got %b expected 0", zero); end
    if (in_ready !== 1'b1) begin mismatched++; $display("[TB] FAIL reset in_ready: got %b expected 1", in_ready); end
  endtask

  task automatic test_directed();
    logic [63:0] f[6];
    logic [12:0] e[6];
    logic [12:0] s[6];
    logic [63:0] vm[6];
    res_t        x[6];
    res_t        g;
    f[0] = 64'h0000_0000_0000_00F0; e[0] = 13'd10;  s[0] = 13'd56;    vm[0] = '1;
    x[0] = {64'hF000_0000_0000_0000, 13'h1FD2, 1'b0, 1'b0};
    f[1] = 64'h8000_0000_0000_000F; e[1] = 13'd5;   s[1] = 13'h1FFC;  vm[1] = '1;
    x[1] = {64'h0800_0000_0000_0000, 13'd9, 1'b1, 1'b0};
    f[2] = 64'h1;                   e[2] = 13'd100; s[2] = 13'h1000;  vm[2] = '1;
    x[2] = {64'h0, 13'h1064, 1'b1, 1'b1};
    f[3] = '1;                      e[3] = 13'd0;   s[3] = 13'd64;    vm[3] = '1;
    x[3] = {64'h0, 13'h1FC0, 1'b0, 1'b1};
    f[4] = 64'h8000_0000_0000_0001; e[4] = 13'd0;   s[4] = 13'h1FC1;  vm[4] = '1;
    x[4] = {64'h1, 13'h003F, 1'b1, 1'b0};
    f[5] = '1;                      e[5] = 13'd7;   s[5] = 13'd0;     vm[5] = 64'h00FF_00FF_00FF_00FF;
    x[5] = {64'h00FF_00FF_00FF_00FF, 13'd7, 1'b0, 1'b0};
    for (int i = 0; i < 6; i++) stepCycle(1'b1, 1'b1, f[i], e[i], s[i], vm[i]);
    drain();
    compared++;
    if (gotQ.size() != 6) begin
      mismatched++;
      $display("[TB] FAIL directed count: got %0d results expected 6", gotQ.size());
    end
    for (int i = 0; i < 6 && gotQ.size() > 0; i++) begin
      g = gotQ.pop_front();
      compared++;
      if (g !== x[i]) begin
        mismatched++;
        $display("[TB] FAIL directed vec%0d: got fo=%h eo=%h st=%b z=%b expected fo=%h eo=%h st=%b z=%b",
                 i, g.fo, g.eo, g.sticky, g.zero, x[i].fo, x[i].eo, x[i].sticky, x[i].zero);
      end
    end
    gotQ.delete();
    expQ.delete();
  endtask

  task automatic test_random();
    res_t g;
    res_t x;
    for (int i = 0; i < 300; i++) begin
      stepCycle($urandom_range(0, 3) != 0, $urandom_range(0, 3) != 0, randSig(), 13'($urandom),
                randShift(), ($urandom_range(0, 1) != 0) ? '1 : {$urandom, $urandom});
    end
    drain();
    compared++;
    if (gotQ.size() != expQ.size()) begin
      mismatched++;
      $display("[TB] FAIL random count: got %0d results expected %0d", gotQ.size(), expQ.size());
    end
    while (gotQ.size() > 0 && expQ.size() > 0) begin
      g = gotQ.pop_front();
      x = expQ.pop_front();
      compared++;
      if (g !== x) begin
        mismatched++;
        $display("[TB] FAIL random result: got fo=%h eo=%h st=%b z=%b expected fo=%h eo=%h st=%b z=%b",
                 g.fo, g.eo, g.sticky, g.zero, x.fo, x.eo, x.sticky, x.zero);
      end
    end
    gotQ.delete();
    expQ.delete();
  endtask

  task automatic test_back_to_back();
    res_t g;
    res_t x;
    logic expOv;
    drain();
    for (int k = 0; k < 20; k++) begin
      stepCycle(k < 16, 1'b1, randSig(), 13'($urandom), randShift(), '1);
      expOv = (k >= 2 && k <= 17);
      compared += 2;
      if (out_valid !== expOv) begin
        mismatched++;
        $display("[TB] FAIL b2b out_valid step %0d: got %b expected %b", k, out_valid, expOv);
      end
      if (in_ready !== 1'b1) begin
        mismatched++;
        $display("[TB] FAIL b2b in_ready step %0d: got %b expected 1", k, in_ready);
      end
    end
    compared++;
    if (gotQ.size() != 16 || expQ.size() != 16) begin
      mismatched++;
      $display("[TB] FAIL b2b count: got %0d results expected 16 (accepted %0d)", gotQ.size(), expQ.size());
    end
    while (gotQ.size() > 0 && expQ.size() > 0) begin
      g = gotQ.pop_front();
      x = expQ.pop_front();
      compared++;
      if (g !== x) begin
        mismatched++;
        $display("[TB] FAIL b2b result: got fo=%h eo=%h expected fo=%h eo=%h", g.fo, g.eo, x.fo, x.eo);
      end
    end
    gotQ.delete();
    expQ.delete();
  endtask

  task automatic test_backpressure();
    logic       ordyPat[12] = '{1, 1, 0, 0, 0, 1, 1, 1, 1, 1, 1, 1};
    int         nextOp = 0;
    logic       expIr;
    logic       sawDrop = 1'b0;
    logic       wasStalled = 1'b0;
    res_t       held;
    res_t       g;
    res_t       x;
    drain();
    for (int k = 0; k < 12; k++) begin
      expIr = ((accepted - emitted) < 2) || ordyPat[k];
      stepCycle(nextOp < 4, ordyPat[k], randSig(), 13'($urandom), randShift(), '1);
      compared++;
      if (in_ready !== expIr) begin
        mismatched++;
        $display("[TB] FAIL bp in_ready step %0d: got %b expected %b", k, in_ready, expIr);
      end
      if (!in_ready) sawDrop = 1'b1;
      if (in_valid && in_ready) nextOp++;
      if (out_valid && !out_ready) begin
        if (wasStalled) begin
          compared++;
          if ({fo, eo, sticky, zero} !== held) begin
            mismatched++;
            $display("[TB] FAIL bp stall hold step %0d: got fo=%h eo=%h expected fo=%h eo=%h",
                     k, fo, eo, held.fo, held.eo);
          end
        end
        held = {fo, eo, sticky, zero};
        wasStalled = 1'b1;
      end else begin
        wasStalled = 1'b0;
      end
    end
    drain();
    compared += 2;
    if (sawDrop !== 1'b1) begin
      mismatched++;
      $display("[TB] FAIL bp in_ready drop: got %b expected 1", sawDrop);
    end
    if (gotQ.size() != 4 || expQ.size() != 4) begin
      mismatched++;
      $display("[TB] FAIL bp count: got %0d results expected 4 (accepted %0d)", gotQ.size(), expQ.size());
    end
    while (gotQ.size() > 0 && expQ.size() > 0) begin
      g = gotQ.pop_front();
      x = expQ.pop_front();
      compared++;
      if (g !== x) begin
        mismatched++;
        $display("[TB] FAIL bp result: got fo=%h eo=%h expected fo=%h eo=%h", g.fo, g.eo, x.fo, x.eo);
      end
    end
    gotQ.delete();
    expQ.delete();
  endtask

  task automatic test_reset_midflight();
    drain();
    gotQ.delete();
    expQ.delete();
    stepCycle(1'b1, 1'b0, '1, 13'd21, 13'd0, '1);
    stepCycle(1'b1, 1'b0, 64'hFF, 13'd3, 13'h1FFE, '1);
    rst = 1'b1;
    idleCycle(1'b0);
    rst = 1'b0;
    expQ.delete();
    emitted = accepted;
    idleCycle(1'b1);
    compared += 5;
    if (out_valid !== 1'b0) begin mismatched++; $display("[TB] FAIL midrst out_valid: got %b expected 0", out_valid); end
    if (fo !== 64'd0) begin mismatched++; $display("[TB] FAIL midrst fo: got %h expected 0", fo); end
    if (eo !== 13'd0) begin mismatched++; $display("[TB] FAIL midrst eo: got %h expected 0", eo); end
    if (sticky !== 1'b0) begin mismatched++; $display("[TB] FAIL midrst sticky: got %b expected 0", sticky); end
    if (zero !== 1'b0) begin mismatched++; $display("[TB] FAIL midrst zero: got %b expected 0", zero); end
    for (int k = 0; k < 6; k++) begin
      idleCycle(1'b1);
      compared++;
      if (out_valid !== 1'b0) begin
        mismatched++;
        $display("[TB] FAIL midrst ghost step %0d: got out_valid %b expected 0", k, out_valid);
      end
    end
    compared++;
    if (gotQ.size() != 0) begin
      mismatched++;
      $display("[TB] FAIL midrst emitted: got %0d results expected 0", gotQ.size());
    end
    gotQ.delete();
  endtask

  initial begin
    rst       = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    fi = '0;
    ei = '0;
    sh = '0;
    v  = '0;
    w  = '0;
    test_reset();
    test_directed();
    test_back_to_back();
    test_backpressure();
    test_random();
    test_reset_midflight();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL timeout: simulation did not complete within bound");
    $fatal(1, "[TB] timeout");
  end

endmodule

// File: doc/norm_shift.md
Name: norm_shift

Overview:
- Two-stage pipelined normalization/denormalization shifter in the rounder datapath.
- Consumes the significand, the 13-bit signed shift distance, and the v/w mask pair produced combinationally from that shift distance by the rounder mask generator.
- Produces the shifted significand, adjusted exponent and sticky bit for the round-decision stage.
- Valid/ready handshake on both sides; full throughput of one operand per cycle.

Parameters:
- WF, 64, significand width; shift masks are also WF bits wide.
- WE, 13, exponent and shift-distance width, two's complement.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  synchronous reset, active-high.
- in_valid  in  1  upstream operand valid.
- in_ready  out  1  block accepts the operand this cycle.
- fi  in  WF  input significand, bit WF-1 = MSB.
- ei  in  WE  input exponent, two's complement.
- sh  in  WE  shift distance: positive = left shift, negative = right shift.
- v  in  WF  keep mask for the current sh, from the mask generator.
- w  in  WF  lost-bit mask for the current sh, from the mask generator; zero when sh >= 0.
- out_valid  out  1  result valid.
- out_ready  in  1  downstream accepts the result.
- fo  out  WF  shifted significand.
- eo  out  WE  adjusted exponent.
- sticky  out  1  OR of all significand bits lost by a right shift.
- zero  out  1  fo == 0.

Behaviour:
- Reset: s1_valid = s2_valid = 0; out_valid = 0; fo, eo, sticky and zero all 0. in_ready is 1 in the cycle after reset deasserts.
- Accept: an operand is accepted on a rising edge when in_valid && in_ready.
- Stage 1 capture: fi, ei, sh and v are registered, and s1_sticky = |(fi & w) is computed. w is sampled in the same cycle as sh.
- Stage 2:
  - If sh >= 0: shifted = fi << sh.
  - If sh < 0: shifted = fi >> |sh|.
  - Saturation: if |sh| >= WF, shifted = 0. This includes sh = -4096, whose magnitude must be handled without overflow.
  - fo = shifted & v_reg.
  - eo = ei - sh, modulo 2^WE (wraps, no saturation).
  - zero = (fo == 0).
  - sticky = s1_sticky.
- Latency: exactly 2 cycles from accept to out_valid when out_ready stays high.
- Flow control:
  - s2 advances when !s2_valid || out_ready.
  - s1 advances when !s1_valid || s2 advances.
  - in_ready = s1 advances (combinational from out_ready).
  - There is no skid buffer; both stages may be full.
- Stall: while out_valid && !out_ready, fo, eo, sticky and zero hold stable, and the s1 contents hold.
- Back-to-back operation: with in_valid and out_ready held high, one result per cycle, in order, with no bubbles.
- Simultaneous events:
  - Accept into s1 and drain of s2 in the same cycle is legal.
  - A full pipeline with out_ready = 1 accepts a new operand that cycle.
- Mid-operation reset: rst wins over every other event. In-flight operands are discarded, all outputs return to reset values the next cycle, and nothing in flight is emitted later.
- Output gating: outputs other than out_valid are don't-care while out_valid = 0, but must still hold the reset value until the first result.

Test Plan:
- Left normalize: fi = 64'h0000_0000_0000_00F0, ei = 10, sh = 56, v = all ones, w = 0 -> 2 cycles later fo = 64'hF000_0000_0000_0000, eo = 13'h1FD2 (-46), sticky = 0, zero = 0.
- Right shift with loss: fi = 64'h8000_0000_0000_000F, ei = 5, sh = -4 (13'h1FFC), v = all ones, w = 64'h0000_0000_0000_000F -> fo = 64'h0800_0000_0000_0000, eo = 9, sticky = 1.
- Saturation: fi = 64'h1, sh = -4096, w = all ones -> fo = 0, zero = 1, sticky = 1, eo = ei + 4096 mod 8192.
- Backpressure: stream 4 operands with out_ready low for 3 cycles mid-stream -> in_ready drops once both stages are full, outputs stay stable while stalled, all 4 results emerge in order with none lost or duplicated.
- Throughput: 16 consecutive operands with in_valid = out_ready = 1 -> 16 consecutive out_valid cycles starting at cycle 2.
- Reset mid-flight: two operands in the pipe, assert rst for 1 cycle -> next cycle out_valid = 0, fo = 0, sticky = 0; neither operand ever appears at the output.
